// File: rtl/multiplier_ctrl_if.sv
// Handshake and datapath-control bundle between the core, multiplier_ctrl
// and the 4-lane rotating multiplier datapath.
// MULT_CTRL_FUSE_EN adds the reuse_i request qualifier.
interface multiplier_ctrl_if;
    logic       start_i;
    logic [1:0] funct3_i;
`ifdef MULT_CTRL_FUSE_EN
    logic       reuse_i;
`endif
    logic       busy_o;
    logic       done_o;
    logic       reg_A_en_o;
    logic       reg_B_en_o;
    logic       mux_B_sel_o;
    logic       rol_en_o;
    logic       en_pipe_o;
    logic       AC_en_o;
    logic       ac_clr_o;
    logic [1:0] shift_amount_o;
    logic       signed_A_o;
    logic       signed_B_o;
    logic       upper_o;

`ifdef MULT_CTRL_FUSE_EN
    modport master (
        output start_i, funct3_i, reuse_i,
        input  busy_o, done_o, reg_A_en_o, reg_B_en_o, mux_B_sel_o, rol_en_o,
               en_pipe_o, AC_en_o, ac_clr_o, shift_amount_o,
               signed_A_o, signed_B_o, upper_o
    );
    modport slave (
        input  start_i, funct3_i, reuse_i,
        output busy_o, done_o, reg_A_en_o, reg_B_en_o, mux_B_sel_o, rol_en_o,
               en_pipe_o, AC_en_o, ac_clr_o, shift_amount_o,
               signed_A_o, signed_B_o, upper_o
    );
`else
    modport master (
        output start_i, funct3_i,
        input  busy_o, done_o, reg_A_en_o, reg_B_en_o, mux_B_sel_o, rol_en_o,
               en_pipe_o, AC_en_o, ac_clr_o, shift_amount_o,
               signed_A_o, signed_B_o, upper_o
    );
    modport slave (
        input  start_i, funct3_i,
        output busy_o, done_o, reg_A_en_o, reg_B_en_o, mux_B_sel_o, rol_en_o,
               en_pipe_o, AC_en_o, ac_clr_o, shift_amount_o,
               signed_A_o, signed_B_o, upper_o
    );
`endif
endinterface

// File: rtl/multiplier_ctrl.sv
// Control FSM for the 4-lane rotating RV32M multiplier datapath.
// Sequence: IDLE -> PHASE x4 -> DRAIN x PIPE_DEPTH -> DONE -> IDLE.
// Optional feature macro: MULT_CTRL_FUSE_EN (operand-reuse fast path).
module multiplier_ctrl #(
    parameter int PIPE_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    multiplier_ctrl_if.slave  bus
);

    // r_cyc counts cycles since the accepted start (c1 = first PHASE cycle)
    localparam logic [3:0] LAST_PHASE = 4'd4;
    localparam logic [3:0] LAST_BUSY  = 4'(PIPE_DEPTH + 4);
    localparam logic [3:0] AC_FIRST   = 4'(PIPE_DEPTH);
    localparam logic [3:0] AC_LAST    = 4'(PIPE_DEPTH + 3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PHASE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cyc;
    logic [3:0] w_cyc_nxt;

    logic       w_accept;
    logic       w_fuse;
    logic       w_dec_sA;
    logic       w_dec_sB;
    logic       w_dec_up;
    logic       w_fuse_sA;
    logic       w_fuse_sB;
    logic [1:0] w_phase;

    // A request is only taken when no operation is in flight
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start_i;

    // funct3 is only valid in the start cycle, so decode it combinationally
    assign w_dec_sA = (bus.funct3_i == 2'b01) || (bus.funct3_i == 2'b10);
    assign w_dec_sB = (bus.funct3_i == 2'b01);
    assign w_dec_up = (bus.funct3_i != 2'b00);

    // PHASE cycles c1..c4 map onto rotation phase 0..3
    assign w_phase = r_cyc[1:0] - 2'd1;

`ifdef MULT_CTRL_FUSE_EN
    logic       r_hist_vld;
    logic [1:0] r_last_f3;
    logic       r_last_sA;
    logic       r_last_sB;
    logic [1:0] r_pend_f3;
    logic       r_pend_sA;
    logic       r_pend_sB;

    // Same operands as the last completed op: B register already holds rs2
    assign w_fuse = w_accept && bus.reuse_i && r_hist_vld &&
                    ((bus.funct3_i == 2'b00) || (bus.funct3_i == r_last_f3));
    assign w_fuse_sA = r_last_sA;
    assign w_fuse_sB = r_last_sB;

    // Track the decode of the op in flight and commit it on completion
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hist_vld <= 1'b0;
            r_last_f3  <= 2'b00;
            r_last_sA  <= 1'b0;
            r_last_sB  <= 1'b0;
            r_pend_f3  <= 2'b00;
            r_pend_sA  <= 1'b0;
            r_pend_sB  <= 1'b0;
        end else begin
            if (w_accept && !w_fuse) begin
                r_pend_f3 <= bus.funct3_i;
                r_pend_sA <= w_dec_sA;
                r_pend_sB <= w_dec_sB;
            end
            if ((r_state == S_DRAIN) && (r_cyc == LAST_BUSY)) begin
                r_hist_vld <= 1'b1;
                r_last_f3  <= r_pend_f3;
                r_last_sA  <= r_pend_sA;
                r_last_sB  <= r_pend_sB;
            end
        end
    end
`else
    assign w_fuse    = 1'b0;
    assign w_fuse_sA = 1'b0;
    assign w_fuse_sB = 1'b0;
`endif

    // State and cycle-counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cyc   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    // Next-state: DONE behaves like IDLE for new requests
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept && w_fuse) begin
                    w_state_nxt = S_DONE;
                    w_cyc_nxt   = 4'd0;
                end else if (w_accept) begin
                    w_state_nxt = S_PHASE;
                    w_cyc_nxt   = 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cyc_nxt   = 4'd0;
                end
            end
            S_PHASE: begin
                w_cyc_nxt = r_cyc + 4'd1;
                if (r_cyc == LAST_PHASE) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_cyc_nxt = r_cyc + 4'd1;
                if (r_cyc == LAST_BUSY) begin
                    w_state_nxt = S_DONE;
                    w_cyc_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cyc_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs: start-cycle controls come straight from start_i; all forced low in reset
    always_comb begin
        bus.busy_o         = 1'b0;
        bus.done_o         = 1'b0;
        bus.reg_A_en_o     = 1'b0;
        bus.reg_B_en_o     = 1'b0;
        bus.mux_B_sel_o    = 1'b0;
        bus.rol_en_o       = 1'b0;
        bus.en_pipe_o      = 1'b0;
        bus.AC_en_o        = 1'b0;
        bus.ac_clr_o       = 1'b0;
        bus.shift_amount_o = 2'b00;
        bus.signed_A_o     = 1'b0;
        bus.signed_B_o     = 1'b0;
        bus.upper_o        = 1'b0;
        if (rst_n_i) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    bus.done_o = (r_state == S_DONE);
                    if (w_accept) begin
                        bus.reg_A_en_o = 1'b1;
                        bus.upper_o    = w_dec_up;
                        if (w_fuse) begin
                            bus.signed_A_o = w_fuse_sA;
                            bus.signed_B_o = w_fuse_sB;
                        end else begin
                            bus.reg_B_en_o = 1'b1;
                            bus.ac_clr_o   = 1'b1;
                            bus.signed_A_o = w_dec_sA;
                            bus.signed_B_o = w_dec_sB;
                        end
                    end
                end
                S_PHASE: begin
                    bus.busy_o         = 1'b1;
                    bus.en_pipe_o      = 1'b1;
                    bus.reg_B_en_o     = 1'b1;
                    bus.mux_B_sel_o    = 1'b1;
                    bus.rol_en_o       = 1'b1;
                    bus.shift_amount_o = {w_phase[1], w_phase[1] ^ w_phase[0]};
                end
                S_DRAIN: begin
                    bus.busy_o    = 1'b1;
                    bus.en_pipe_o = 1'b1;
                end
                default: begin
                    bus.busy_o = 1'b0;
                end
            endcase
            bus.AC_en_o = bus.busy_o && (r_cyc >= AC_FIRST) && (r_cyc <= AC_LAST);
        end
    end

endmodule
